fractal_sync_aggr_node: RTL and testbench
=========================================

Name: fractal_sync_aggr_node

Overview:
- Aggregation node of the fractal synchronization tree. Collects barrier requests from its two child sides: est/north (EN) and west/south (WS).
- When both sides have arrived for the same (level, id), it does one of two things:
  - forwards a single request upward, or
  - if this node is the barrier root, issues the response back down to both sides.
- It also relays responses arriving from the parent down to both children.
- Half-arrived barriers are held in a small CAM register file.

Parameters:
- NODE_LEVEL, 1, tree level of this node; a request with level == NODE_LEVEL terminates here.
- LVL_W, 3, width of the level field.
- ID_W, 4, width of the barrier id field.
- RF_DEPTH, 4, number of CAM entries for half-arrived barriers.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  synchronous reset, active-high.
- en_req_valid_i / en_req_ready_o  in/out  1  EN child request handshake.
- en_req_level_i  in  LVL_W  EN request target level.
- en_req_id_i  in  ID_W  EN request barrier id.
- ws_req_valid_i / ws_req_ready_o  in/out  1  WS child request handshake.
- ws_req_level_i  in  LVL_W  WS request target level.
- ws_req_id_i  in  ID_W  WS request barrier id.
- up_req_valid_o / up_req_ready_i  out/in  1  request to parent.
- up_req_level_o / up_req_id_o  out  LVL_W/ID_W  forwarded key.
- up_rsp_valid_i / up_rsp_ready_o  in/out  1  response from parent.
- up_rsp_level_i / up_rsp_id_i  in  LVL_W/ID_W  parent response key.
- en_rsp_valid_o / en_rsp_ready_i  out/in  1  response to EN child.
- ws_rsp_valid_o / ws_rsp_ready_i  out/in  1  response to WS child.
- dn_rsp_level_o / dn_rsp_id_o  out  LVL_W/ID_W  response key, shared by both sides.

Behaviour:
- Reset: all valid outputs 0, all level/id outputs 0, CAM entries invalid, rr pointer = EN, err_o = 0 (if present).
- Key = {level, id}. A CAM entry holds {valid, side, level, id}.
- Match rule: an incoming request matches an entry with the same key and the opposite side.
- Up slot (registered):
  - free = !up_req_valid_o | up_req_ready_i.
- Down slot (registered, fanned out to both sides):
  - Per-side done flags; each side's valid drops after its own handshake.
  - Slot clears once both sides are done. Handshakes may complete in the same or different cycles.
  - free = slot empty.
- Parent response:
  - up_rsp_ready_o = down slot free.
  - Has priority over a local root match for the down slot.
- Pair path: both request valids high, same key, no CAM hit.
  - Both accepted in the same cycle, nothing stored.
  - Requires the relevant output slot free.
- Single path: one request processed per cycle, chosen by round-robin.
  - rr pointer toggles after each single-path accept.
  - The non-chosen side's ready = 0.
- Per chosen request:
  - level == NODE_LEVEL and match: needs the down slot free and no parent response that cycle. Accept, invalidate the entry, load the down slot.
  - level > NODE_LEVEL and match: needs the up slot free. Accept, invalidate the entry, load the up slot.
  - No match: needs a free CAM entry. Accept, write the lowest-index free entry. RF full means ready = 0 (stall, never drop).
  - level < NODE_LEVEL: accepted and discarded.
  - Same-side duplicate key already stored: accepted and discarded.
- Latency: accept in cycle N; up/down valid in N+1.
- Output hold: outputs stay stable while valid && !ready.
- Simultaneous CAM invalidate and allocate of the same index in one cycle: the allocation wins.
- Reset mid-operation: all pending barriers and in-flight slots are lost; no output glitches after reset.

Optional Feature:
- Macro FRACTAL_SYNC_AGGR_ERR_EN.
- Defined: adds port err_o (out, 1).
  - Sticky; set the cycle after a discarded request (level < NODE_LEVEL or same-side duplicate).
  - Cleared only by reset.
- Undefined: no err_o port; discards are silent and the logic is removed.

Decomposition:
- In fractal_sync_pkg:
  - aggr_key_t struct {level, id}.
  - cam_entry_t {valid, sd_e side, aggr_key_t key}.
  - Reuse sd_e SD_EST_NORTH / SD_WEST_SOUTH as side encoding.
- Sub-module fractal_sync_cam_rf:
  - RF_DEPTH entries; one combinational lookup per port; lowest-free allocate; invalidate by index; full flag.

Test Plan:
- Single EN req level=2,id=5, then WS req level=2,id=5 three cycles later:
  - first stored (CAM occupancy 1);
  - up_req valid the cycle after the WS accept with level=2,id=5;
  - CAM empty afterwards.
- EN and WS both level=1,id=3 in the same cycle:
  - both readies high;
  - next cycle en_rsp/ws_rsp valid with level=1,id=3.
  - With en_rsp_ready_i=1, ws_rsp_ready_i=0 for 2 cycles: EN valid drops after 1 cycle, WS valid holds.
- Five distinct EN-only keys, RF_DEPTH=4:
  - first four accepted; fifth sees en_req_ready_o=0 until the matching WS req frees an entry.
- up_rsp level=2,id=1 and a local root pair in the same cycle:
  - parent response goes down first;
  - local pair stalls one slot, then is delivered.
- up_req_ready_i=0 for 5 cycles with a pending forward:
  - up_req_* held stable;
  - next matching forward stalls the input (ready=0).
- With FRACTAL_SYNC_AGGR_ERR_EN, EN req level=0 at NODE_LEVEL=1:
  - accepted, no output;
  - err_o=1 next cycle, stays 1 until rst_i.

Source files
------------

// File: rtl/fractal_sync_pkg.sv
// rtl/fractal_sync_pkg.sv - shared types for the fractal sync tree: barrier key, CAM entry, side encoding
package fractal_sync_pkg;

    localparam int unsigned AGGR_LVL_W = 3;
    localparam int unsigned AGGR_ID_W  = 4;

    typedef enum logic {
        SD_EST_NORTH  = 1'b0,
        SD_WEST_SOUTH = 1'b1
    } sd_e;

    typedef struct packed {
        logic [AGGR_LVL_W-1:0] level;
        logic [AGGR_ID_W-1:0]  id;
    } aggr_key_t;

    typedef struct packed {
        logic      valid;
        sd_e       side;
        aggr_key_t key;
    } cam_entry_t;

    function automatic sd_e sd_opposite(input sd_e s);
        return (s == SD_EST_NORTH) ? SD_WEST_SOUTH : SD_EST_NORTH;
    endfunction

endpackage

// File: rtl/fractal_sync_aggr_node_if.sv
// rtl/fractal_sync_aggr_node_if.sv - request/response channels of one aggregation node
interface fractal_sync_aggr_node_if #(
    parameter int unsigned LVL_W = 3,
    parameter int unsigned ID_W  = 4
) ();
    logic             en_req_valid_i, en_req_ready_o;
    logic [LVL_W-1:0] en_req_level_i;
    logic [ID_W-1:0]  en_req_id_i;
    logic             ws_req_valid_i, ws_req_ready_o;
    logic [LVL_W-1:0] ws_req_level_i;
    logic [ID_W-1:0]  ws_req_id_i;
    logic             up_req_valid_o, up_req_ready_i;
    logic [LVL_W-1:0] up_req_level_o;
    logic [ID_W-1:0]  up_req_id_o;
    logic             up_rsp_valid_i, up_rsp_ready_o;
    logic [LVL_W-1:0] up_rsp_level_i;
    logic [ID_W-1:0]  up_rsp_id_i;
    logic             en_rsp_valid_o, en_rsp_ready_i;
    logic             ws_rsp_valid_o, ws_rsp_ready_i;
    logic [LVL_W-1:0] dn_rsp_level_o;
    logic [ID_W-1:0]  dn_rsp_id_o;

    modport slave (
        input  en_req_valid_i, en_req_level_i, en_req_id_i,
        output en_req_ready_o,
        input  ws_req_valid_i, ws_req_level_i, ws_req_id_i,
        output ws_req_ready_o,
        output up_req_valid_o, up_req_level_o, up_req_id_o,
        input  up_req_ready_i,
        input  up_rsp_valid_i, up_rsp_level_i, up_rsp_id_i,
        output up_rsp_ready_o,
        output en_rsp_valid_o, ws_rsp_valid_o, dn_rsp_level_o, dn_rsp_id_o,
        input  en_rsp_ready_i, ws_rsp_ready_i
    );

    modport master (
        output en_req_valid_i, en_req_level_i, en_req_id_i,
        input  en_req_ready_o,
        output ws_req_valid_i, ws_req_level_i, ws_req_id_i,
        input  ws_req_ready_o,
        input  up_req_valid_o, up_req_level_o, up_req_id_o,
        output up_req_ready_i,
        output up_rsp_valid_i, up_rsp_level_i, up_rsp_id_i,
        input  up_rsp_ready_o,
        input  en_rsp_valid_o, ws_rsp_valid_o, dn_rsp_level_o, dn_rsp_id_o,
        output en_rsp_ready_i, ws_rsp_ready_i
    );
endinterface

// File: rtl/fractal_sync_aggr_node_cam_rf.sv
// rtl/fractal_sync_aggr_node_cam_rf.sv - CAM of half-arrived barriers; two lookup ports, lowest-free allocate
module fractal_sync_cam_rf
    import fractal_sync_pkg::*;
#(
    parameter int unsigned RF_DEPTH = 4,
    parameter int unsigned IDX_W    = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  aggr_key_t        lk_key_i  [2],
    input  sd_e              lk_side_i [2],
    output logic [1:0]       lk_hit_o,
    output logic [1:0]       lk_dup_o,
    output logic [IDX_W-1:0] lk_idx_o  [2],
    input  logic             alloc_i,
    input  sd_e              alloc_side_i,
    input  aggr_key_t        alloc_key_i,
    input  logic             inv_i,
    input  logic [IDX_W-1:0] inv_idx_i,
    output logic             full_o
);
    cam_entry_t       ent_q [RF_DEPTH];
    cam_entry_t       ent_d [RF_DEPTH];
    logic [IDX_W-1:0] free_idx;
    logic             found_free;

    // hit = same key stored by the opposite side; dup = same key already stored by this side
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            lk_hit_o[p] = 1'b0;
            lk_dup_o[p] = 1'b0;
            lk_idx_o[p] = '0;
            for (int i = 0; i < RF_DEPTH; i++) begin
                if (ent_q[i].valid && ent_q[i].key == lk_key_i[p]) begin
                    if (ent_q[i].side != lk_side_i[p]) begin
                        if (!lk_hit_o[p]) begin
                            lk_hit_o[p] = 1'b1;
                            lk_idx_o[p] = IDX_W'(i);
                        end
                    end else begin
                        lk_dup_o[p] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        found_free = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < RF_DEPTH; i++) begin
            if (!ent_q[i].valid && !found_free) begin
                found_free = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign full_o = !found_free;

    always_comb begin
        ent_d = ent_q;
        if (inv_i) ent_d[inv_idx_i].valid = 1'b0;
        if (alloc_i && found_free) begin
            ent_d[free_idx] = '{valid: 1'b1, side: alloc_side_i, key: alloc_key_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < RF_DEPTH; i++) ent_q[i] <= '0;
        end else begin
            ent_q <= ent_d;
        end
    end
endmodule

// File: rtl/fractal_sync_aggr_node.sv
// rtl/fractal_sync_aggr_node.sv - barrier aggregation node; FRACTAL_SYNC_AGGR_ERR_EN adds sticky err_o
module fractal_sync_aggr_node
    import fractal_sync_pkg::*;
#(
    parameter int unsigned NODE_LEVEL = 1,
    parameter int unsigned LVL_W      = AGGR_LVL_W,
    parameter int unsigned ID_W       = AGGR_ID_W,
    parameter int unsigned RF_DEPTH   = 4
) (
    input  logic clk_i,
    input  logic rst_i,
`ifdef FRACTAL_SYNC_AGGR_ERR_EN
    output logic err_o,
`endif
    fractal_sync_aggr_node_if.slave bus
);
    localparam int unsigned      IDX_W    = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1;
    localparam logic [LVL_W-1:0] NODE_LVL = LVL_W'(NODE_LEVEL);

    aggr_key_t        req_key  [2];
    sd_e              req_side [2];
    logic [1:0]       req_v, lk_hit, lk_dup, can_acc, want_up, want_dn, want_alloc;
    logic [IDX_W-1:0] lk_idx   [2];
    logic [IDX_W-1:0] inv_idx;
    logic             cam_full, cam_alloc, cam_inv;
    sd_e              alloc_side;
    aggr_key_t        alloc_key, ld_key, rsp_key;
    logic             en_rdy, ws_rdy, load_up, load_dn, sel_ws;
    logic             up_free, dn_free, par_take, pair_cand, pair_root, pair_ok;

    logic      up_vld_q, up_vld_d, dn_en_q, dn_en_d, dn_ws_q, dn_ws_d;
    aggr_key_t up_key_q, up_key_d, dn_key_q, dn_key_d;
    sd_e       rr_q, rr_d;

    assign req_key[0]  = '{level: bus.en_req_level_i, id: bus.en_req_id_i};
    assign req_key[1]  = '{level: bus.ws_req_level_i, id: bus.ws_req_id_i};
    assign req_side[0] = SD_EST_NORTH;
    assign req_side[1] = SD_WEST_SOUTH;
    assign req_v       = {bus.ws_req_valid_i, bus.en_req_valid_i};
    assign rsp_key     = '{level: bus.up_rsp_level_i, id: bus.up_rsp_id_i};

    fractal_sync_cam_rf #(.RF_DEPTH(RF_DEPTH), .IDX_W(IDX_W)) u_cam (
        .clk_i(clk_i), .rst_i(rst_i),
        .lk_key_i(req_key), .lk_side_i(req_side),
        .lk_hit_o(lk_hit), .lk_dup_o(lk_dup), .lk_idx_o(lk_idx),
        .alloc_i(cam_alloc), .alloc_side_i(alloc_side), .alloc_key_i(alloc_key),
        .inv_i(cam_inv), .inv_idx_i(inv_idx), .full_o(cam_full)
    );

    assign up_free   = !up_vld_q || bus.up_req_ready_i;
    assign dn_free   = !dn_en_q && !dn_ws_q;
    assign par_take  = bus.up_rsp_valid_i && dn_free;
    assign pair_cand = (&req_v) && (req_key[0] == req_key[1]) &&
                       (req_key[0].level >= NODE_LVL) && !(|{lk_hit, lk_dup});
    assign pair_root = (req_key[0].level == NODE_LVL);
    assign pair_ok   = pair_root ? (dn_free && !bus.up_rsp_valid_i) : up_free;

    // Whether each side could be accepted on the single path this cycle
    always_comb begin
        can_acc = '0; want_up = '0; want_dn = '0; want_alloc = '0;
        for (int s = 0; s < 2; s++) begin
            if (req_v[s]) begin
                if (req_key[s].level < NODE_LVL) begin
                    can_acc[s] = 1'b1;
                end else if (lk_hit[s]) begin
                    if (req_key[s].level == NODE_LVL) begin
                        if (dn_free && !bus.up_rsp_valid_i) begin
                            can_acc[s] = 1'b1;
                            want_dn[s] = 1'b1;
                        end
                    end else if (up_free) begin
                        can_acc[s] = 1'b1;
                        want_up[s] = 1'b1;
                    end
                end else if (lk_dup[s]) begin
                    can_acc[s] = 1'b1;
                end else if (!cam_full) begin
                    can_acc[s]    = 1'b1;
                    want_alloc[s] = 1'b1;
                end
            end
        end
    end

    // rr only arbitrates between sides that can progress, so a stalled side never blocks the other
    always_comb begin
        en_rdy = 1'b0; ws_rdy = 1'b0; load_up = 1'b0; load_dn = 1'b0; sel_ws = 1'b0;
        ld_key = req_key[0]; cam_alloc = 1'b0; cam_inv = 1'b0; inv_idx = lk_idx[0];
        alloc_side = SD_EST_NORTH; alloc_key = req_key[0]; rr_d = rr_q;
        if (pair_cand) begin
            if (pair_ok) begin
                en_rdy  = 1'b1;
                ws_rdy  = 1'b1;
                load_dn = pair_root;
                load_up = !pair_root;
            end
        end else if (|can_acc) begin
            sel_ws     = can_acc[1] && (!can_acc[0] || rr_q == SD_WEST_SOUTH);
            en_rdy     = !sel_ws;
            ws_rdy     = sel_ws;
            ld_key     = req_key[sel_ws];
            load_up    = want_up[sel_ws];
            load_dn    = want_dn[sel_ws];
            cam_inv    = want_up[sel_ws] || want_dn[sel_ws];
            inv_idx    = lk_idx[sel_ws];
            cam_alloc  = want_alloc[sel_ws];
            alloc_side = req_side[sel_ws];
            alloc_key  = req_key[sel_ws];
            rr_d       = sd_opposite(rr_q);
        end
    end

    always_comb begin
        up_vld_d = up_vld_q && !bus.up_req_ready_i;
        up_key_d = up_key_q;
        if (load_up) begin
            up_vld_d = 1'b1;
            up_key_d = ld_key;
        end
        dn_en_d  = dn_en_q && !bus.en_rsp_ready_i;
        dn_ws_d  = dn_ws_q && !bus.ws_rsp_ready_i;
        dn_key_d = dn_key_q;
        if (par_take) begin
            dn_en_d  = 1'b1;
            dn_ws_d  = 1'b1;
            dn_key_d = rsp_key;
        end else if (load_dn) begin
            dn_en_d  = 1'b1;
            dn_ws_d  = 1'b1;
            dn_key_d = ld_key;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            up_vld_q <= 1'b0;
            up_key_q <= '0;
            dn_en_q  <= 1'b0;
            dn_ws_q  <= 1'b0;
            dn_key_q <= '0;
            rr_q     <= SD_EST_NORTH;
        end else begin
            up_vld_q <= up_vld_d;
            up_key_q <= up_key_d;
            dn_en_q  <= dn_en_d;
            dn_ws_q  <= dn_ws_d;
            dn_key_q <= dn_key_d;
            rr_q     <= rr_d;
        end
    end

`ifdef FRACTAL_SYNC_AGGR_ERR_EN
    logic err_q, err_d;
    logic [1:0] disc;
    always_comb begin
        disc = '0;
        for (int s = 0; s < 2; s++) begin
            disc[s] = req_v[s] && ((req_key[s].level < NODE_LVL) || (!lk_hit[s] && lk_dup[s]));
        end
        err_d = err_q || (disc[0] && en_rdy) || (disc[1] && ws_rdy);
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) err_q <= 1'b0;
        else       err_q <= err_d;
    end
    assign err_o = err_q;
`endif

    assign bus.en_req_ready_o = en_rdy;
    assign bus.ws_req_ready_o = ws_rdy;
    assign bus.up_req_valid_o = up_vld_q;
    assign bus.up_req_level_o = LVL_W'(up_key_q.level);
    assign bus.up_req_id_o    = ID_W'(up_key_q.id);
    assign bus.up_rsp_ready_o = dn_free;
    assign bus.en_rsp_valid_o = dn_en_q;
    assign bus.ws_rsp_valid_o = dn_ws_q;
    assign bus.dn_rsp_level_o = LVL_W'(dn_key_q.level);
    assign bus.dn_rsp_id_o    = ID_W'(dn_key_q.id);
endmodule

// File: tb/tb_fractal_sync_aggr_node.sv
// tb/tb_fractal_sync_aggr_node.sv - directed scoreboard bench; FRACTAL_SYNC_AGGR_ERR_EN also covers err_o
module tb_fractal_sync_aggr_node;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fractal_sync_aggr_node_if #(.LVL_W(3), .ID_W(4)) nif ();
`ifdef FRACTAL_SYNC_AGGR_ERR_EN
    logic err_w;
`endif

    fractal_sync_aggr_node #(.NODE_LEVEL(1), .LVL_W(3), .ID_W(4), .RF_DEPTH(4)) dut (
        .clk_i(clk),
        .rst_i(rst),
`ifdef FRACTAL_SYNC_AGGR_ERR_EN
        .err_o(err_w),
`endif
        .bus(nif)
    );

    logic [6:0] up_q[$];
    logic [6:0] en_q[$];
    logic [6:0] ws_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [6:0] key(input logic [2:0] l, input logic [3:0] i);
        return {l, i};
    endfunction

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive_en(input logic [2:0] l, input logic [3:0] i);
        nif.en_req_valid_i = 1'b1; nif.en_req_level_i = l; nif.en_req_id_i = i;
    endtask

    task automatic drive_ws(input logic [2:0] l, input logic [3:0] i);
        nif.ws_req_valid_i = 1'b1; nif.ws_req_level_i = l; nif.ws_req_id_i = i;
    endtask

    task automatic idle();
        nif.en_req_valid_i = 1'b0; nif.ws_req_valid_i = 1'b0; nif.up_rsp_valid_i = 1'b0;
    endtask

    logic       up_hold = 1'b0, en_hold = 1'b0, ws_hold = 1'b0;
    logic [6:0] up_prev = '0, dn_prev = '0;
    logic [6:0] exp_k;

    always @(negedge clk) begin
        if (rst) begin
            up_hold = 1'b0; en_hold = 1'b0; ws_hold = 1'b0;
        end else begin
            if (up_hold) chk("up_hold", {nif.up_req_valid_o, nif.up_req_level_o, nif.up_req_id_o}, {1'b1, up_prev});
            if (en_hold) chk("en_hold", {nif.en_rsp_valid_o, nif.dn_rsp_level_o, nif.dn_rsp_id_o}, {1'b1, dn_prev});
            if (ws_hold) chk("ws_hold", {nif.ws_rsp_valid_o, nif.dn_rsp_level_o, nif.dn_rsp_id_o}, {1'b1, dn_prev});
            if (nif.up_req_valid_o && nif.up_req_ready_i) begin
                chk("up_expected", 32'(up_q.size() != 0), 1);
                if (up_q.size() != 0) begin
                    exp_k = up_q.pop_front();
                    chk("up_key", {nif.up_req_level_o, nif.up_req_id_o}, exp_k);
                end
            end
            if (nif.en_rsp_valid_o && nif.en_rsp_ready_i) begin
                chk("en_rsp_expected", 32'(en_q.size() != 0), 1);
                if (en_q.size() != 0) begin
                    exp_k = en_q.pop_front();
                    chk("en_rsp_key", {nif.dn_rsp_level_o, nif.dn_rsp_id_o}, exp_k);
                end
            end
            if (nif.ws_rsp_valid_o && nif.ws_rsp_ready_i) begin
                chk("ws_rsp_expected", 32'(ws_q.size() != 0), 1);
                if (ws_q.size() != 0) begin
                    exp_k = ws_q.pop_front();
                    chk("ws_rsp_key", {nif.dn_rsp_level_o, nif.dn_rsp_id_o}, exp_k);
                end
            end
            up_hold = nif.up_req_valid_o && !nif.up_req_ready_i;
            en_hold = nif.en_rsp_valid_o && !nif.en_rsp_ready_i;
            ws_hold = nif.ws_rsp_valid_o && !nif.ws_rsp_ready_i;
            up_prev = {nif.up_req_level_o, nif.up_req_id_o};
            dn_prev = {nif.dn_rsp_level_o, nif.dn_rsp_id_o};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        nif.en_req_valid_i = 0; nif.en_req_level_i = 0; nif.en_req_id_i = 0;
        nif.ws_req_valid_i = 0; nif.ws_req_level_i = 0; nif.ws_req_id_i = 0;
        nif.up_rsp_valid_i = 0; nif.up_rsp_level_i = 0; nif.up_rsp_id_i = 0;
        nif.up_req_ready_i = 1; nif.en_rsp_ready_i = 1; nif.ws_rsp_ready_i = 1;
        rst = 1'b1;
        cyc(3);
        #1;
        chk("rst_up_valid", nif.up_req_valid_o, 0);
        chk("rst_en_rsp_valid", nif.en_rsp_valid_o, 0);
        chk("rst_ws_rsp_valid", nif.ws_rsp_valid_o, 0);
        chk("rst_up_key", {nif.up_req_level_o, nif.up_req_id_o}, 0);
        chk("rst_dn_key", {nif.dn_rsp_level_o, nif.dn_rsp_id_o}, 0);
        chk("rst_up_rsp_ready", nif.up_rsp_ready_o, 1);
`ifdef FRACTAL_SYNC_AGGR_ERR_EN
        chk("rst_err", err_w, 0);
`endif
        rst = 1'b0;
        cyc();

        // split arrival forwarded upward
        drive_en(2, 5); #1 chk("t1_en_rdy", nif.en_req_ready_o, 1); cyc(); idle();
        repeat (3) begin #1 chk("t1_no_up", nif.up_req_valid_o, 0); cyc(); end
        drive_ws(2, 5); up_q.push_back(key(2, 5));
        #1 chk("t1_ws_rdy", nif.ws_req_ready_o, 1); cyc(); idle();
        #1 chk("t1_up_valid", nif.up_req_valid_o, 1);
        chk("t1_up_key", {nif.up_req_level_o, nif.up_req_id_o}, key(2, 5));
        cyc();

        // root pair with uneven child readiness
        nif.ws_rsp_ready_i = 0;
        drive_en(1, 3); drive_ws(1, 3); en_q.push_back(key(1, 3)); ws_q.push_back(key(1, 3));
        #1 chk("t2_en_rdy", nif.en_req_ready_o, 1); chk("t2_ws_rdy", nif.ws_req_ready_o, 1);
        cyc(); idle();
        #1 chk("t2_rsp_valids", {nif.en_rsp_valid_o, nif.ws_rsp_valid_o}, 2'b11);
        chk("t2_dn_key", {nif.dn_rsp_level_o, nif.dn_rsp_id_o}, key(1, 3));
        cyc();
        #1 chk("t2_split_1", {nif.en_rsp_valid_o, nif.ws_rsp_valid_o}, 2'b01); cyc();
        #1 chk("t2_split_2", {nif.en_rsp_valid_o, nif.ws_rsp_valid_o}, 2'b01);
        nif.ws_rsp_ready_i = 1; cyc();
        #1 chk("t2_done", {nif.en_rsp_valid_o, nif.ws_rsp_valid_o}, 2'b00); cyc();

        // CAM fill and full stall
        for (int k = 0; k < 4; k++) begin
            drive_en(2, 4'(8 + k)); #1 chk("t3_fill_rdy", nif.en_req_ready_o, 1); cyc();
        end
        drive_en(2, 12);
        repeat (2) begin #1 chk("t3_full_stall", nif.en_req_ready_o, 0); cyc(); end
        drive_ws(2, 8); up_q.push_back(key(2, 8));
        #1 chk("t3_ws_match_rdy", nif.ws_req_ready_o, 1); chk("t3_en_still_stall", nif.en_req_ready_o, 0);
        cyc(); nif.ws_req_valid_i = 0;
        #1 chk("t3_en_after_free", nif.en_req_ready_o, 1); cyc(); idle();
        for (int k = 0; k < 4; k++) begin
            drive_ws(2, 4'(9 + k)); up_q.push_back(key(2, 4'(9 + k)));
            #1 chk("t3_drain_rdy", nif.ws_req_ready_o, 1); cyc();
        end
        idle(); cyc();

        // parent response beats a local root pair
        nif.up_rsp_valid_i = 1; nif.up_rsp_level_i = 2; nif.up_rsp_id_i = 1;
        drive_en(1, 6); drive_ws(1, 6);
        en_q.push_back(key(2, 1)); ws_q.push_back(key(2, 1));
        en_q.push_back(key(1, 6)); ws_q.push_back(key(1, 6));
        #1 chk("t4_up_rsp_rdy", nif.up_rsp_ready_o, 1);
        chk("t4_pair_stall", {nif.en_req_ready_o, nif.ws_req_ready_o}, 2'b00);
        cyc(); nif.up_rsp_valid_i = 0;
        #1 chk("t4_par_first", {nif.en_rsp_valid_o, nif.dn_rsp_level_o, nif.dn_rsp_id_o}, {1'b1, key(2, 1)});
        n = 0;
        while (nif.en_req_ready_o !== 1'b1 && n < 6) begin cyc(); #1; n++; end
        chk("t4_pair_rdy", {nif.en_req_ready_o, nif.ws_req_ready_o}, 2'b11);
        chk("t4_stall_cycles", n, 1);
        cyc(); idle();
        #1 chk("t4_pair_key", {nif.ws_rsp_valid_o, nif.dn_rsp_level_o, nif.dn_rsp_id_o}, {1'b1, key(1, 6)});
        cyc();

        // parent back-pressure on the up slot
        nif.up_req_ready_i = 0;
        drive_en(3, 2); cyc(); idle();
        drive_ws(3, 2); up_q.push_back(key(3, 2));
        #1 chk("t5_ws_rdy", nif.ws_req_ready_o, 1); cyc(); idle();
        drive_en(3, 4);
        #1 chk("t5_hold_a", {nif.up_req_valid_o, nif.up_req_level_o, nif.up_req_id_o}, {1'b1, key(3, 2)});
        chk("t5_en_store_rdy", nif.en_req_ready_o, 1); cyc(); idle();
        drive_ws(3, 4);
        repeat (4) begin
            #1 chk("t5_fwd_stall", nif.ws_req_ready_o, 0);
            chk("t5_hold_b", {nif.up_req_valid_o, nif.up_req_level_o, nif.up_req_id_o}, {1'b1, key(3, 2)});
            cyc();
        end
        nif.up_req_ready_i = 1; up_q.push_back(key(3, 4));
        #1 chk("t5_fwd_rdy", nif.ws_req_ready_o, 1); cyc(); idle();
        #1 chk("t5_reload", {nif.up_req_valid_o, nif.up_req_level_o, nif.up_req_id_o}, {1'b1, key(3, 4)});
        cyc();

        // discards: below node level and same-side duplicate
        drive_en(0, 1); #1 chk("t6_low_rdy", nif.en_req_ready_o, 1);
`ifdef FRACTAL_SYNC_AGGR_ERR_EN
        chk("t6_err_before", err_w, 0);
`endif
        cyc(); idle();
        #1 chk("t6_no_out", {nif.up_req_valid_o, nif.en_rsp_valid_o, nif.ws_rsp_valid_o}, 0);
`ifdef FRACTAL_SYNC_AGGR_ERR_EN
        chk("t6_err_set", err_w, 1);
`endif
        cyc(3);
`ifdef FRACTAL_SYNC_AGGR_ERR_EN
        #1 chk("t6_err_sticky", err_w, 1);
`endif
        drive_en(2, 7); cyc();
        #1 chk("t6_dup_rdy", nif.en_req_ready_o, 1); cyc(); idle();
        drive_ws(2, 7); up_q.push_back(key(2, 7));
        #1 chk("t6_dup_pair_rdy", nif.ws_req_ready_o, 1); cyc(); idle(); cyc(2);

        // reset mid-operation drops the stored half
        drive_en(4, 1); cyc(); idle();
        rst = 1'b1; cyc(2);
        #1 chk("t7_rst_outs", {nif.up_req_valid_o, nif.en_rsp_valid_o, nif.ws_rsp_valid_o}, 0);
`ifdef FRACTAL_SYNC_AGGR_ERR_EN
        chk("t7_err_cleared", err_w, 0);
`endif
        rst = 1'b0; cyc();
        drive_ws(4, 1); #1 chk("t7_ws_rdy", nif.ws_req_ready_o, 1); cyc(); idle();
        #1 chk("t7_no_up", nif.up_req_valid_o, 0); cyc(2);
        drive_en(4, 1); up_q.push_back(key(4, 1));
        #1 chk("t7_en_rdy", nif.en_req_ready_o, 1); cyc(); idle();
        #1 chk("t7_up_valid", nif.up_req_valid_o, 1); cyc(3);

        chk("end_up_q_empty", up_q.size(), 0);
        chk("end_en_q_empty", en_q.size(), 0);
        chk("end_ws_q_empty", ws_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
